// File: rtl/execute_mdu.sv
// Execute stage: forwarding, ALU, branch target, EX/MEM register and an iterative RV32M multiply/divide unit.
// Optional feature macro: MDU_EARLY_OUT_EN (trivial multiplies skip BUSY, divides terminate once dividend is exhausted).
module execute_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_d,
  input  logic                     reg_write_d,
  input  logic                     mem_write_d,
  input  logic                     jump_d,
  input  logic                     branch_d,
  input  logic                     alu_src_a_d,
  input  logic                     alu_src_b_d,
  input  logic                     adder_src_d,
  input  logic [1:0]               res_src_d,
  input  logic [3:0]               alu_control_d,
  input  logic [2:0]               funct3_d,
  input  logic                     md_en_d,
  input  logic [DATA_WIDTH-1:0]    rd1_d,
  input  logic [DATA_WIDTH-1:0]    rd2_d,
  input  logic [DATA_WIDTH-1:0]    imm_val_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_d,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  input  logic [4:0]               rd_d,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic [1:0]               forward_a_e,
  input  logic [1:0]               forward_b_e,
  input  logic                     flush_e,
  output logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     pc_src_e,
  output logic                     stall_e,
  output logic                     reg_write_m,
  output logic                     mem_write_m,
  output logic [1:0]               res_src_m,
  output logic [2:0]               funct3_m,
  output logic [4:0]               rd_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    write_data_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int SW = $clog2(DW);
  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_INIT = CW'(DW);

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8,  ALU_SRA  = 4'd9,  ALU_PASSB = 4'd10, ALU_EQ = 4'd11;
  localparam logic [3:0] ALU_NE   = 4'd12, ALU_GE   = 4'd13, ALU_GEU = 4'd14;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} mdu_state_e;
  mdu_state_e state_r, state_nx_s;

  logic [DW-1:0]   fwd_a_s, fwd_b_s, src_a_s, src_b_s, alu_res_s, md_res_s;
  logic [SW-1:0]   shamt_s;
  logic [2:0]      op_r;
  logic [CW-1:0]   cnt_r;
  logic [2*DW-1:0] acc_r, acc_init_s, step_s, prod_s;
  logic [DW-1:0]   b_mag_r, a_mag_s, b_mag_s, quo_s, rem_s, div_diff_s;
  logic [DW:0]     mul_sum_s, div_rs_s;
  logic            neg_q_r, neg_r_r, div_ge_s;
  logic            is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic            start_s, div_zero_s, div_ovf_s, mul_skip_s, skip_s, early_div_s, bubble_s;

  // Operand forwarding muxes
  always_comb begin
    case (forward_a_e)
      2'b01:   fwd_a_s = alu_result_m;
      2'b10:   fwd_a_s = result_w;
      default: fwd_a_s = rd1_d;
    endcase
    case (forward_b_e)
      2'b01:   fwd_b_s = alu_result_m;
      2'b10:   fwd_b_s = result_w;
      default: fwd_b_s = rd2_d;
    endcase
  end

  // ALU source selection and operation
  always_comb begin
    src_a_s = alu_src_a_d ? DW'(pc_d) : fwd_a_s;
    src_b_s = alu_src_b_d ? imm_val_d : fwd_b_s;
    shamt_s = src_b_s[SW-1:0];
    case (alu_control_d)
      ALU_ADD:   alu_res_s = src_a_s + src_b_s;
      ALU_SUB:   alu_res_s = src_a_s - src_b_s;
      ALU_AND:   alu_res_s = src_a_s & src_b_s;
      ALU_OR:    alu_res_s = src_a_s | src_b_s;
      ALU_XOR:   alu_res_s = src_a_s ^ src_b_s;
      ALU_SLT:   alu_res_s = {{(DW-1){1'b0}}, $signed(src_a_s) < $signed(src_b_s)};
      ALU_SLTU:  alu_res_s = {{(DW-1){1'b0}}, src_a_s < src_b_s};
      ALU_SLL:   alu_res_s = src_a_s << shamt_s;
      ALU_SRL:   alu_res_s = src_a_s >> shamt_s;
      ALU_SRA:   alu_res_s = $unsigned($signed(src_a_s) >>> shamt_s);
      ALU_PASSB: alu_res_s = src_b_s;
      ALU_EQ:    alu_res_s = {{(DW-1){1'b0}}, src_a_s == src_b_s};
      ALU_NE:    alu_res_s = {{(DW-1){1'b0}}, src_a_s != src_b_s};
      ALU_GE:    alu_res_s = {{(DW-1){1'b0}}, $signed(src_a_s) >= $signed(src_b_s)};
      ALU_GEU:   alu_res_s = {{(DW-1){1'b0}}, src_a_s >= src_b_s};
      default:   alu_res_s = ZERO;
    endcase
  end

  assign pc_target_e = (adder_src_d ? AW'(rd1_d) : pc_d) + AW'(imm_val_d);
  assign pc_src_e    = valid_d & ~flush_e & (jump_d | (branch_d & alu_res_s[0]));

  // MDU operand decode: funct3[2] selects divide; signedness from the low bits
  assign is_div_s   = funct3_d[2];
  assign a_sgn_s    = is_div_s ? ~funct3_d[0] : (funct3_d[1:0] == 2'b01) | (funct3_d[1:0] == 2'b10);
  assign b_sgn_s    = is_div_s ? ~funct3_d[0] : (funct3_d[1:0] == 2'b01);
  assign a_neg_s    = a_sgn_s & fwd_a_s[DW-1];
  assign b_neg_s    = b_sgn_s & fwd_b_s[DW-1];
  assign a_mag_s    = a_neg_s ? -fwd_a_s : fwd_a_s;
  assign b_mag_s    = b_neg_s ? -fwd_b_s : fwd_b_s;
  assign start_s    = (state_r == S_IDLE) & valid_d & md_en_d & ~flush_e;
  assign div_zero_s = is_div_s & (fwd_b_s == ZERO);
  assign div_ovf_s  = is_div_s & ~funct3_d[0] & (fwd_a_s == SMIN) & (fwd_b_s == ONES);
`ifdef MDU_EARLY_OUT_EN
  assign mul_skip_s  = ~is_div_s & (b_mag_s[DW-1:1] == {(DW-1){1'b0}});
  assign early_div_s = op_r[2] & (acc_r[2*DW-1:DW] == ZERO)
                     & ((acc_r[DW-1:0] >> (DW - int'(cnt_r))) == ZERO);
`else
  assign mul_skip_s  = 1'b0;
  assign early_div_s = 1'b0;
`endif
  assign skip_s   = div_zero_s | div_ovf_s | mul_skip_s;
  assign stall_e  = start_s | (state_r == S_BUSY);
  assign bubble_s = stall_e | flush_e | ~valid_d;

  // Accumulator preload; special divides are preloaded with their final {remainder, quotient}
  always_comb begin
    if (div_zero_s) begin
      acc_init_s = {fwd_a_s, ONES};
    end else if (div_ovf_s) begin
      acc_init_s = {ZERO, SMIN};
    end else if (mul_skip_s & ~b_mag_s[0]) begin
      acc_init_s = {2*DW{1'b0}};
    end else begin
      acc_init_s = {ZERO, a_mag_s};
    end
  end

  // One shift-add multiply step or one restoring-divide step
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*DW-1:DW]} + {1'b0, b_mag_r};
    div_rs_s   = acc_r[2*DW-1:DW-1];
    div_ge_s   = div_rs_s >= {1'b0, b_mag_r};
    div_diff_s = div_rs_s[DW-1:0] - b_mag_r;
    if (op_r[2]) begin
      step_s = div_ge_s ? {div_diff_s, acc_r[DW-2:0], 1'b1} : {div_rs_s[DW-1:0], acc_r[DW-2:0], 1'b0};
    end else begin
      step_s = acc_r[0] ? {mul_sum_s, acc_r[DW-1:1]} : {1'b0, acc_r[2*DW-1:1]};
    end
  end

  // Sign correction and result selection presented in DONE
  always_comb begin
    prod_s = neg_q_r ? -acc_r : acc_r;
    quo_s  = neg_q_r ? -acc_r[DW-1:0] : acc_r[DW-1:0];
    rem_s  = neg_r_r ? -acc_r[2*DW-1:DW] : acc_r[2*DW-1:DW];
    case (op_r)
      3'b000:                 md_res_s = prod_s[DW-1:0];
      3'b001, 3'b010, 3'b011: md_res_s = prod_s[2*DW-1:DW];
      3'b100, 3'b101:         md_res_s = quo_s;
      3'b110, 3'b111:         md_res_s = rem_s;
      default:                md_res_s = ZERO;
    endcase
  end

  // MDU next-state logic; flush wins in every state
  always_comb begin
    state_nx_s = state_r;
    if (flush_e) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  state_nx_s = start_s ? (skip_s ? S_DONE : S_BUSY) : S_IDLE;
        S_BUSY:  state_nx_s = ((cnt_r == CNT_ONE) | early_div_s) ? S_DONE : S_BUSY;
        S_DONE:  state_nx_s = S_IDLE;
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // MDU state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // MDU datapath: capture operands at start, iterate while BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= 3'b000;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {2*DW{1'b0}};
      b_mag_r <= ZERO;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (start_s) begin
      op_r    <= funct3_d;
      cnt_r   <= CNT_INIT;
      acc_r   <= acc_init_s;
      b_mag_r <= b_mag_s;
      neg_q_r <= (a_neg_s ^ b_neg_s) & ~(div_zero_s | div_ovf_s);
      neg_r_r <= a_neg_s & ~(div_zero_s | div_ovf_s);
    end else if (state_r == S_BUSY) begin
      cnt_r <= cnt_r - CNT_ONE;
`ifdef MDU_EARLY_OUT_EN
      acc_r <= early_div_s ? {ZERO, acc_r[DW-1:0] << cnt_r} : step_s;
`else
      acc_r <= step_s;
`endif
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble_s) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      res_src_m    <= 2'b00;
      funct3_m     <= 3'b000;
      rd_m         <= 5'd0;
      alu_result_m <= ZERO;
      write_data_m <= ZERO;
      pc_plus4_m   <= {AW{1'b0}};
    end else begin
      reg_write_m  <= reg_write_d;
      mem_write_m  <= mem_write_d;
      res_src_m    <= res_src_d;
      funct3_m     <= funct3_d;
      rd_m         <= rd_d;
      alu_result_m <= (state_r == S_DONE) ? md_res_s : alu_res_s;
      write_data_m <= fwd_b_s;
      pc_plus4_m   <= pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// Directed self-checking bench for execute_mdu (default build, DATA_WIDTH = ADDRESS_WIDTH = 32).
module tb_execute_mdu;
  logic clk = 1'b0;
  logic rst_n;
  logic valid_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_a_d, alu_src_b_d, adder_src_d;
  logic [1:0]  res_src_d, forward_a_e, forward_b_e;
  logic [3:0]  alu_control_d;
  logic [2:0]  funct3_d;
  logic        md_en_d, flush_e;
  logic [31:0] rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d, result_w;
  logic [4:0]  rd_d;
  logic [31:0] pc_target_e;
  logic        pc_src_e, stall_e, reg_write_m, mem_write_m;
  logic [1:0]  res_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_mdu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d),
    .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d), .adder_src_d(adder_src_d),
    .res_src_d(res_src_d), .alu_control_d(alu_control_d), .funct3_d(funct3_d),
    .md_en_d(md_en_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_val_d(imm_val_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd_d(rd_d), .result_w(result_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .flush_e(flush_e),
    .pc_target_e(pc_target_e), .pc_src_e(pc_src_e), .stall_e(stall_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .res_src_m(res_src_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    valid_d = 1'b0; reg_write_d = 1'b0; mem_write_d = 1'b0; jump_d = 1'b0; branch_d = 1'b0;
    alu_src_a_d = 1'b0; alu_src_b_d = 1'b0; adder_src_d = 1'b0; res_src_d = 2'b00;
    alu_control_d = 4'd0; funct3_d = 3'b000; md_en_d = 1'b0; rd1_d = 32'd0; rd2_d = 32'd0;
    imm_val_d = 32'd0; pc_d = 32'd0; pc_plus4_d = 32'd0; rd_d = 5'd0; result_w = 32'd0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; flush_e = 1'b0;
  endtask

  task automatic set_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    valid_d = 1'b1; md_en_d = 1'b1; reg_write_d = 1'b1; funct3_d = f3;
    rd1_d = a; rd2_d = b; rd_d = 5'd7; pc_plus4_d = 32'h200;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    valid_d = 1'b1; reg_write_d = 1'b1; rd1_d = 32'd10; rd2_d = 32'd5; rd_d = 5'd3; pc_plus4_d = 32'h44;
    step(); step();
    checks++;
    if ({reg_write_m, mem_write_m, res_src_m, funct3_m, rd_m} !== 13'd0)
      $display("FAIL reset_ctrl: got %h expected 0", {reg_write_m, mem_write_m, res_src_m, funct3_m, rd_m});
    checks++;
    if (alu_result_m !== 32'd0 || write_data_m !== 32'd0 || pc_plus4_m !== 32'd0)
      $display("FAIL reset_data: got %h/%h/%h expected 0", alu_result_m, write_data_m, pc_plus4_m);
    checks++;
    if (stall_e !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_e);
    errors += (({reg_write_m, mem_write_m, res_src_m, funct3_m, rd_m} !== 13'd0) ? 1 : 0)
            + ((alu_result_m !== 32'd0 || write_data_m !== 32'd0 || pc_plus4_m !== 32'd0) ? 1 : 0)
            + ((stall_e !== 1'b0) ? 1 : 0);
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_forward;
    idle_inputs();
    valid_d = 1'b1; reg_write_d = 1'b1; alu_control_d = 4'd0;
    rd1_d = 32'd10; rd2_d = 32'd5; rd_d = 5'd3; pc_plus4_d = 32'h104;
    step();
    checks++;
    if (alu_result_m !== 32'd15 || reg_write_m !== 1'b1 || rd_m !== 5'd3 || pc_plus4_m !== 32'h104) begin
      errors++;
      $display("FAIL add_basic: got %0d rw=%b rd=%0d pc4=%h expected 15 1 3 104", alu_result_m, reg_write_m, rd_m, pc_plus4_m);
    end
    rd1_d = 32'hDEAD; rd2_d = 32'd1; forward_a_e = 2'b01;
    step();
    checks++;
    if (alu_result_m !== 32'd16) begin
      errors++; $display("FAIL add_fwd_mem: got %0d expected 16", alu_result_m);
    end
    forward_a_e = 2'b10; result_w = 32'd100;
    step();
    checks++;
    if (alu_result_m !== 32'd101) begin
      errors++; $display("FAIL add_fwd_wb: got %0d expected 101", alu_result_m);
    end
    forward_a_e = 2'b00; rd1_d = 32'd50; alu_src_b_d = 1'b1; imm_val_d = 32'd8;
    alu_control_d = 4'd1; mem_write_d = 1'b1; reg_write_d = 1'b0;
    step();
    checks++;
    if (alu_result_m !== 32'd42 || write_data_m !== 32'd1 || mem_write_m !== 1'b1 || reg_write_m !== 1'b0) begin
      errors++;
      $display("FAIL sub_imm_store: got %0d wd=%0d mw=%b rw=%b expected 42 1 1 0", alu_result_m, write_data_m, mem_write_m, reg_write_m);
    end
    flush_e = 1'b1;
    step();
    checks++;
    if (mem_write_m !== 1'b0 || reg_write_m !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got mw=%b rw=%b expected 0 0", mem_write_m, reg_write_m);
    end
    flush_e = 1'b0; valid_d = 1'b0;
    step();
    checks++;
    if (mem_write_m !== 1'b0) begin
      errors++; $display("FAIL invalid_bubble: got mw=%b expected 0", mem_write_m);
    end
    idle_inputs();
  endtask

  task automatic test_branch;
    idle_inputs();
    valid_d = 1'b1; branch_d = 1'b1; alu_control_d = 4'd11;
    rd1_d = 32'd42; rd2_d = 32'd42; pc_d = 32'h100; imm_val_d = 32'h20;
    #1;
    checks++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h120) begin
      errors++; $display("FAIL beq_taken: got src=%b tgt=%h expected 1 120", pc_src_e, pc_target_e);
    end
    rd2_d = 32'd43;
    #1;
    checks++;
    if (pc_src_e !== 1'b0) begin
      errors++; $display("FAIL beq_not_taken: got %b expected 0", pc_src_e);
    end
    branch_d = 1'b0; jump_d = 1'b1; adder_src_d = 1'b1; rd1_d = 32'h400; imm_val_d = 32'h8;
    #1;
    checks++;
    if (pc_src_e !== 1'b1 || pc_target_e !== 32'h408) begin
      errors++; $display("FAIL jalr_target: got src=%b tgt=%h expected 1 408", pc_src_e, pc_target_e);
    end
    flush_e = 1'b1;
    #1;
    checks++;
    if (pc_src_e !== 1'b0) begin
      errors++; $display("FAIL jump_flushed: got %b expected 0", pc_src_e);
    end
    idle_inputs();
    step();
  endtask

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_val, input int exp_stall, input string name);
    int n;
    int bad;
    set_md(f3, a, b);
    #1;
    n = 0; bad = 0;
    while (stall_e === 1'b1 && n < 100) begin
      if (n > 0 && reg_write_m !== 1'b0) bad++;
      n++;
      step();
    end
    checks++;
    if (n != exp_stall) begin
      errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_stall);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s early_write: got %0d writes during stall expected 0", name, bad);
    end
    step();
    checks++;
    if (alu_result_m !== exp_val || reg_write_m !== 1'b1 || rd_m !== 5'd7) begin
      errors++;
      $display("FAIL %s result: got %h rw=%b rd=%0d expected %h 1 7", name, alu_result_m, reg_write_m, rd_m, exp_val);
    end
    idle_inputs();
    step();
    checks++;
    if (reg_write_m !== 1'b0) begin
      errors++; $display("FAIL %s single_write: got rw=%b expected 0", name, reg_write_m);
    end
  endtask

  task automatic test_mdu;
    run_md(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run_md(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run_md(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu");
    run_md(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    run_md(3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33, "mulh_neg");
    run_md(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by_zero");
    run_md(3'b110, 32'd5,        32'd0,        32'd5,        1,  "rem_by_zero");
    run_md(3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,  "div_neg_by_zero");
    run_md(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "rem_neg_by_zero");
    run_md(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_overflow");
    run_md(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_overflow");
    run_md(3'b111, 32'd17,       32'd5,        32'd2,        33, "remu");
    run_md(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_signed");
    run_md(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_signed");
    run_md(3'b101, 32'd100,      32'd7,        32'd14,       33, "divu");
  endtask

  task automatic test_flush;
    int stray;
    set_md(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (stall_e !== 1'b1) begin
      errors++; $display("FAIL flush_pre_busy: got stall=%b expected 1", stall_e);
    end
    flush_e = 1'b1; valid_d = 1'b0;
    step();
    flush_e = 1'b0;
    #1;
    checks++;
    if (stall_e !== 1'b0 || reg_write_m !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got stall=%b rw=%b expected 0 0", stall_e, reg_write_m);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (reg_write_m !== 1'b0 || stall_e !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL flush_discard: got %0d stray cycles expected 0", stray);
    end
    run_md(3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");
  endtask

  task automatic test_reset_mid;
    int n;
    set_md(3'b000, 32'd7, 32'd3);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (stall_e !== 1'b0 || reg_write_m !== 1'b0 || alu_result_m !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_busy: got stall=%b rw=%b res=%h expected 0 0 0", stall_e, reg_write_m, alu_result_m);
    end
    step();
    rst_n = 1'b1;
    step();
    run_md(3'b000, 32'd7, 32'd3, 32'd21, 33, "mul_after_reset");
    set_md(3'b000, 32'd9, 32'd9);
    #1;
    n = 0;
    while (stall_e === 1'b1 && n < 100) begin
      n++;
      step();
    end
    rst_n = 1'b0;
    #1;
    step();
    checks++;
    if (reg_write_m !== 1'b0 || alu_result_m !== 32'd0 || n != 33) begin
      errors++;
      $display("FAIL reset_in_done: got rw=%b res=%h stall_cycles=%0d expected 0 0 33", reg_write_m, alu_result_m, n);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_branch();
    test_mdu();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
